rob_param: RTL and testbench
============================

Name: rob_param

Overview:
- Parametrised successor of the single-writeback reorder buffer.
- Configurable depth, configurable number of writeback channels and a configurable almost-full slack.
- Adds a store-commit handshake with the load/store unit, and writeback forwarding on the operand-query path.
- Sits between the commander (dispatch), the execute units, the register file, the fetcher, the predictor and LS.

Parameters:
- DEPTH, 16, number of entries; power of two, at least 4.
- ID_W, 5, ROB id width, equal to log2(DEPTH)+1; id = slot+1, id 0 = invalid.
- NUM_WB, 2, number of writeback channels.
- FULL_SLACK, 5, full_sign asserts when count >= DEPTH-FULL_SLACK.

Ports:
- clk in 1: clock.
- rst in 1: synchronous, active-high reset.
- rdy in 1: global enable; when low, all state holds.
- q1_id in ID_W: operand-1 ROB tag query.
- q2_id in ID_W: operand-2 ROB tag query.
- q1_ready out 1, q2_ready out 1: queried entry has a value.
- v1 out 32, v2 out 32: queried value.
- alloc_en in 1: dispatch one instruction.
- alloc_is_jump in 1, alloc_pred_jump in 1, alloc_is_store in 1.
- alloc_rd in 5, alloc_pc in 32, alloc_rollback_pc in 32.
- alloc_id out ID_W: tail+1.
- wb_valid in NUM_WB: per-channel valid.
- wb_id in NUM_WB*ID_W: per-channel ROB id.
- wb_data in NUM_WB*32: per-channel result.
- wb_jump in NUM_WB: per-channel resolved jump sign.
- wb_target in NUM_WB*32: per-channel jump target.
- commit_sign out 1, commit_rd out 5, commit_id out ID_W, commit_data out 32: register-file commit.
- store_commit_valid out 1, store_commit_id out ID_W: head store may execute.
- store_ack in 1: LS finished the store.
- pdt_en out 1, pdt_pc out 32, pdt_jump out 1: predictor update.
- rollback_sign out 1, rollback_pc out 32: flush and redirect.
- full_sign out 1, empty_sign out 1.

Behaviour:
- Reset (rst=1 at posedge, or rollback_sign=1 at posedge):
  - head=tail=count=0; every busy/ready/flag bit cleared.
  - commit_sign, store_commit_valid, pdt_en and rollback_sign go to 0.
  - commit_rd, commit_id, commit_data, pdt_pc, pdt_jump and rollback_pc reset to 0 on rst only.
  - The commit FSM returns to RUN.
  - rst has priority over rdy.
- rdy=0: no state change, no pulses; outputs hold.
- Pulse outputs (commit_sign, pdt_en, rollback_sign) are high for exactly one cycle.
- Allocation:
  - At a posedge with alloc_en=1, slot tail is filled: busy=1, ready=0, data=0.
  - tail wraps DEPTH-1 -> 0.
  - The commander must not assert alloc_en while full_sign=1; the ROB does not check.
- Writeback:
  - Channel k with wb_valid[k]=1 and busy[id-1]=1 sets ready, data, jump and target.
  - Writebacks to non-busy slots or to id 0 are ignored.
  - If two channels hit the same id, the highest k wins.
  - A writeback to a slot being allocated in the same cycle is ignored; the allocation wins.
- Query (combinational):
  - id 0 -> ready=0, value=0.
  - Otherwise ready = entry ready OR any same-cycle wb_valid channel matching the id.
  - Value is forwarded from the matching channel (highest k) when present, else taken from the entry.
- Commit FSM, states RUN and STORE_WAIT; at most one retire per cycle:
  - RUN, head busy&ready, not a store: retire.
    - If rd!=0: commit_sign=1 with rd, id=head+1, data.
    - If is_jump: pdt_en=1, pdt_pc=pc, pdt_jump=jump.
    - If jump != predicted jump: rollback_sign=1 and rollback_pc = jump ? target : rollback_pc(entry).
    - Free the slot; head advances (wraps).
  - RUN, head busy&ready&is_store: store_commit_valid=1 with store_commit_id=head+1; go to STORE_WAIT. Head is not freed.
  - STORE_WAIT: store_commit_valid stays high. On store_ack=1, free the slot, advance head, drop store_commit_valid and return to RUN. The next head can retire at the earliest one cycle later.
- Count and flags:
  - count += alloc - retire; a simultaneous alloc and retire leaves it unchanged.
  - empty_sign = (count==0).
  - full_sign = (count >= DEPTH-FULL_SLACK), combinational.
- Rollback:
  - The cycle after a rollback pulse, the whole ROB is cleared.
  - Allocations and writebacks in that same clearing cycle are dropped.
  - The flushed instructions never write the register file or the predictor.

Test Plan:
1. Reset, alloc 3 non-jump entries (rd=1,2,3), writeback id 2 then id 1 then id 3 with data 0xA,0xB,0xC -> commits in order rd1=0xB, rd2=0xA, rd3=0xC on consecutive cycles; empty_sign returns to 1.
2. DEPTH=16, FULL_SLACK=5: alloc 11 entries with no retire -> full_sign=1 exactly when count reaches 11; fill/drain 40 entries -> tail and head wrap, ids 16 -> 1, all commit correctly.
3. NUM_WB=2, both channels write id 4 in the same cycle (data 0x11 ch0, 0x22 ch1) -> entry value 0x22; a query of q1_id=4 in that cycle returns ready=1, v1=0x22.
4. Jump entry with pred=0 resolves jump=1, target 0x100 -> pdt_en with jump=1, rollback_sign=1, rollback_pc=0x100; the next cycle count=0 and younger entries never commit.
5. Store at head: store_commit_valid=1 with id; hold store_ack=0 for 5 cycles -> head stalls and a ready younger entry does not commit; ack -> store retires, younger entry commits the following cycle.
6. rdy=0 for 3 cycles with a ready head -> no commit_sign and no state change; reset asserted during STORE_WAIT -> store_commit_valid=0 and FSM returns to RUN next cycle.

Source files
------------

// File: rtl/rob_param.sv
// Reorder buffer with configurable depth and writeback channels: in-order retire,
// store-commit handshake with LS, mispredict rollback and writeback forwarding on queries.
module rob_param #(
  parameter int DEPTH      = 16,
  parameter int ID_W       = 5,
  parameter int NUM_WB     = 2,
  parameter int FULL_SLACK = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic [ID_W-1:0]      q1_id,
  input  logic [ID_W-1:0]      q2_id,
  output logic                 q1_ready,
  output logic                 q2_ready,
  output logic [31:0]          v1,
  output logic [31:0]          v2,
  input  logic                 alloc_en,
  input  logic                 alloc_is_jump,
  input  logic                 alloc_pred_jump,
  input  logic                 alloc_is_store,
  input  logic [4:0]           alloc_rd,
  input  logic [31:0]          alloc_pc,
  input  logic [31:0]          alloc_rollback_pc,
  output logic [ID_W-1:0]      alloc_id,
  input  logic [NUM_WB-1:0]    wb_valid,
  input  logic [NUM_WB*ID_W-1:0] wb_id,
  input  logic [NUM_WB*32-1:0] wb_data,
  input  logic [NUM_WB-1:0]    wb_jump,
  input  logic [NUM_WB*32-1:0] wb_target,
  output logic                 commit_sign,
  output logic [4:0]           commit_rd,
  output logic [ID_W-1:0]      commit_id,
  output logic [31:0]          commit_data,
  output logic                 store_commit_valid,
  output logic [ID_W-1:0]      store_commit_id,
  input  logic                 store_ack,
  output logic                 pdt_en,
  output logic [31:0]          pdt_pc,
  output logic                 pdt_jump,
  output logic                 rollback_sign,
  output logic [31:0]          rollback_pc,
  output logic                 full_sign,
  output logic                 empty_sign
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_TH = CW'(DEPTH - FULL_SLACK);

  typedef enum logic {RUN, STORE_WAIT} cstate_t;

  cstate_t          state, state_nxt;
  logic [AW-1:0]    head, tail;
  logic [CW-1:0]    count, count_nxt;

  logic [DEPTH-1:0] busy, ready_q, is_jmp, pred_jmp, is_st, jmp;
  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      rbpc_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      tgt_q  [DEPTH];

  logic [NUM_WB-1:0] wb_hit;
  logic retire_alu, retire_st, store_issue, retire, mispredict;

  function automatic logic [AW-1:0] id2slot(input logic [ID_W-1:0] id);
    logic [ID_W-1:0] s;
    s = id - ID_W'(1);
    return s[AW-1:0];
  endfunction

  function automatic logic [ID_W-1:0] slot2id(input logic [AW-1:0] slot);
    return ID_W'(slot) + ID_W'(1);
  endfunction

  assign alloc_id   = slot2id(tail);
  assign full_sign  = (count >= FULL_TH);
  assign empty_sign = (count == '0);

  // A writeback lands only on a live slot that is not being re-allocated this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wb_hit = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      wb_hit[k] = wb_valid[k] && (wb_id[k*ID_W +: ID_W] != '0)
                  && busy[id2slot(wb_id[k*ID_W +: ID_W])]
                  && !(alloc_en && (id2slot(wb_id[k*ID_W +: ID_W]) == tail));
    end
  end

  // Operand query with same-cycle forwarding; later channels override earlier ones.
  always_comb begin
    q1_ready = 1'b0;
    v1       = '0;
    q2_ready = 1'b0;
    v2       = '0;
    if (q1_id != '0) begin
      q1_ready = ready_q[id2slot(q1_id)];
      v1       = data_q[id2slot(q1_id)];
      for (int k = 0; k < NUM_WB; k++) begin
        if (wb_valid[k] && (wb_id[k*ID_W +: ID_W] == q1_id)) begin
          q1_ready = 1'b1;
          v1       = wb_data[k*32 +: 32];
        end
      end
    end
    if (q2_id != '0) begin
      q2_ready = ready_q[id2slot(q2_id)];
      v2       = data_q[id2slot(q2_id)];
      for (int k = 0; k < NUM_WB; k++) begin
        if (wb_valid[k] && (wb_id[k*ID_W +: ID_W] == q2_id)) begin
          q2_ready = 1'b1;
          v2       = wb_data[k*32 +: 32];
        end
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    retire_alu  = 1'b0;
    retire_st   = 1'b0;
    store_issue = 1'b0;
    case (state)
      RUN: begin
        if (busy[head] && ready_q[head]) begin
          if (is_st[head]) begin
            store_issue = 1'b1;
            state_nxt   = STORE_WAIT;
          end else begin
            retire_alu = 1'b1;
          end
        end
      end
      STORE_WAIT: begin
        if (store_ack) begin
          retire_st = 1'b1;
          state_nxt = RUN;
        end
      end
    endcase
  end

  assign retire     = retire_alu | retire_st;
  assign mispredict = is_jmp[head] && (jmp[head] != pred_jmp[head]);
  assign count_nxt  = count + CW'(alloc_en) - CW'(retire);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (rst) begin
      state <= RUN;
    end else if (rdy) begin
      state <= rollback_sign ? RUN : state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;  tail <= '0;  count <= '0;
      busy <= '0;  ready_q <= '0;  is_jmp <= '0;
      pred_jmp <= '0;  is_st <= '0;  jmp <= '0;
      commit_sign <= 1'b0;  commit_rd <= '0;  commit_id <= '0;  commit_data <= '0;
      store_commit_valid <= 1'b0;  store_commit_id <= '0;
      pdt_en <= 1'b0;  pdt_pc <= '0;  pdt_jump <= 1'b0;
      rollback_sign <= 1'b0;  rollback_pc <= '0;
    end else if (rdy) begin
      if (rollback_sign) begin
        // Flush cycle: drop everything in flight, including this cycle's alloc/writeback.
        head <= '0;  tail <= '0;  count <= '0;
        busy <= '0;  ready_q <= '0;  is_jmp <= '0;
        pred_jmp <= '0;  is_st <= '0;  jmp <= '0;
        commit_sign <= 1'b0;
        store_commit_valid <= 1'b0;
        pdt_en <= 1'b0;
        rollback_sign <= 1'b0;
      end else begin
        commit_sign   <= 1'b0;
        pdt_en        <= 1'b0;
        rollback_sign <= 1'b0;

        if (alloc_en) begin
          busy[tail]     <= 1'b1;
          ready_q[tail]  <= 1'b0;
          is_jmp[tail]   <= alloc_is_jump;
          pred_jmp[tail] <= alloc_pred_jump;
          is_st[tail]    <= alloc_is_store;
          jmp[tail]      <= 1'b0;
          tail           <= tail + AW'(1);
        end

        for (int k = 0; k < NUM_WB; k++) begin
          if (wb_hit[k]) begin
            ready_q[id2slot(wb_id[k*ID_W +: ID_W])] <= 1'b1;
            jmp[id2slot(wb_id[k*ID_W +: ID_W])]     <= wb_jump[k];
          end
        end

        if (retire_alu) begin
          if (rd_q[head] != '0) begin
            commit_sign <= 1'b1;
            commit_rd   <= rd_q[head];
            commit_id   <= slot2id(head);
            commit_data <= data_q[head];
          end
          if (is_jmp[head]) begin
            pdt_en   <= 1'b1;
            pdt_pc   <= pc_q[head];
            pdt_jump <= jmp[head];
          end
          if (mispredict) begin
            rollback_sign <= 1'b1;
            rollback_pc   <= jmp[head] ? tgt_q[head] : rbpc_q[head];
          end
        end

        if (store_issue) begin
          store_commit_valid <= 1'b1;
          store_commit_id    <= slot2id(head);
        end
        if (retire_st) begin
          store_commit_valid <= 1'b0;
        end

        if (retire) begin
          busy[head]    <= 1'b0;
          ready_q[head] <= 1'b0;
          head          <= head + AW'(1);
        end

        count <= count_nxt;
      end
    end
  end

  // NOTE: payload storage has no reset; busy/ready gate every use, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (rdy && !rst && !rollback_sign) begin
      if (alloc_en) begin
        rd_q[tail]   <= alloc_rd;
        pc_q[tail]   <= alloc_pc;
        rbpc_q[tail] <= alloc_rollback_pc;
        data_q[tail] <= '0;
      end
      for (int k = 0; k < NUM_WB; k++) begin
        if (wb_hit[k]) begin
          data_q[id2slot(wb_id[k*ID_W +: ID_W])] <= wb_data[k*32 +: 32];
          tgt_q[id2slot(wb_id[k*ID_W +: ID_W])]  <= wb_target[k*32 +: 32];
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_param.sv
// Directed bench for rob_param: in-order commit, full/wrap, multi-channel writeback,
// mispredict rollback, store handshake, rdy stall and reset during a store wait.
module tb_rob_param;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [4:0]  q1_id, q2_id;
  logic        q1_ready, q2_ready;
  logic [31:0] v1, v2;
  logic        alloc_en, alloc_is_jump, alloc_pred_jump, alloc_is_store;
  logic [4:0]  alloc_rd;
  logic [31:0] alloc_pc, alloc_rollback_pc;
  logic [4:0]  alloc_id;
  logic [1:0]  wb_valid, wb_jump;
  logic [9:0]  wb_id;
  logic [63:0] wb_data, wb_target;
  logic        commit_sign;
  logic [4:0]  commit_rd, commit_id;
  logic [31:0] commit_data;
  logic        store_commit_valid;
  logic [4:0]  store_commit_id;
  logic        store_ack;
  logic        pdt_en, pdt_jump, rollback_sign, full_sign, empty_sign;
  logic [31:0] pdt_pc, rollback_pc;

  int total = 0;
  int bad   = 0;

  rob_param #(.DEPTH(16), .ID_W(5), .NUM_WB(2), .FULL_SLACK(5)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .v1(v1), .v2(v2),
    .alloc_en(alloc_en), .alloc_is_jump(alloc_is_jump), .alloc_pred_jump(alloc_pred_jump),
    .alloc_is_store(alloc_is_store), .alloc_rd(alloc_rd), .alloc_pc(alloc_pc),
    .alloc_rollback_pc(alloc_rollback_pc), .alloc_id(alloc_id),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data), .wb_jump(wb_jump),
    .wb_target(wb_target),
    .commit_sign(commit_sign), .commit_rd(commit_rd), .commit_id(commit_id),
    .commit_data(commit_data),
    .store_commit_valid(store_commit_valid), .store_commit_id(store_commit_id),
    .store_ack(store_ack),
    .pdt_en(pdt_en), .pdt_pc(pdt_pc), .pdt_jump(pdt_jump),
    .rollback_sign(rollback_sign), .rollback_pc(rollback_pc),
    .full_sign(full_sign), .empty_sign(empty_sign)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc_set(input logic [4:0] rd, input logic is_j, input logic pred,
                           input logic is_s, input logic [31:0] pc, input logic [31:0] rbpc);
    alloc_en = 1'b1;  alloc_rd = rd;  alloc_is_jump = is_j;  alloc_pred_jump = pred;
    alloc_is_store = is_s;  alloc_pc = pc;  alloc_rollback_pc = rbpc;
  endtask

  task automatic alloc_clr();
    alloc_en = 1'b0;  alloc_rd = '0;  alloc_is_jump = 1'b0;  alloc_pred_jump = 1'b0;
    alloc_is_store = 1'b0;  alloc_pc = '0;  alloc_rollback_pc = '0;
  endtask

  task automatic wb_set(input int ch, input logic [4:0] id, input logic [31:0] d,
                        input logic j, input logic [31:0] t);
    wb_valid[ch] = 1'b1;
    wb_id[ch*5 +: 5] = id;
    wb_data[ch*32 +: 32] = d;
    wb_jump[ch] = j;
    wb_target[ch*32 +: 32] = t;
  endtask

  task automatic wb_clr();
    wb_valid = '0;  wb_id = '0;  wb_data = '0;  wb_jump = '0;  wb_target = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0] ids [40];
    rdy = 1'b1;  q1_id = '0;  q2_id = '0;  store_ack = 1'b0;
    alloc_clr();
    wb_clr();
    do_reset();

    // Reset state
    chk("rst_empty", empty_sign, 1);
    chk("rst_full", full_sign, 0);
    chk("rst_alloc_id", alloc_id, 1);
    chk("rst_commit", commit_sign, 0);
    chk("rst_store_valid", store_commit_valid, 0);
    chk("rst_rollback", rollback_sign, 0);
    chk("rst_pdt_en", pdt_en, 0);
    chk("rst_commit_data", commit_data, 0);
    chk("rst_q1_ready", q1_ready, 0);
    chk("rst_v1", v1, 0);

    // 1: out-of-order writeback, in-order commit
    alloc_set(5'd1, 0, 0, 0, 32'h0, 32'h0); step();
    alloc_set(5'd2, 0, 0, 0, 32'h4, 32'h0); step();
    alloc_set(5'd3, 0, 0, 0, 32'h8, 32'h0); step();
    alloc_clr();
    chk("t1_alloc_id", alloc_id, 4);
    chk("t1_not_empty", empty_sign, 0);
    wb_set(0, 5'd2, 32'hA, 0, 0); step();
    chk("t1_no_commit_a", commit_sign, 0);
    wb_set(0, 5'd1, 32'hB, 0, 0); step();
    chk("t1_no_commit_b", commit_sign, 0);
    wb_set(0, 5'd3, 32'hC, 0, 0); step();
    wb_clr();
    chk("t1_c1_sign", commit_sign, 1);
    chk("t1_c1_rd", commit_rd, 1);
    chk("t1_c1_id", commit_id, 1);
    chk("t1_c1_data", commit_data, 32'hB);
    step();
    chk("t1_c2_sign", commit_sign, 1);
    chk("t1_c2_rd", commit_rd, 2);
    chk("t1_c2_data", commit_data, 32'hA);
    step();
    chk("t1_c3_sign", commit_sign, 1);
    chk("t1_c3_rd", commit_rd, 3);
    chk("t1_c3_data", commit_data, 32'hC);
    chk("t1_empty", empty_sign, 1);
    step();
    chk("t1_pulse_end", commit_sign, 0);

    // 2: full threshold at 11 entries (ids 4..14), then drain
    for (int i = 0; i < 11; i++) begin
      alloc_set(5'd5, 0, 0, 0, 32'h100, 32'h0);
      step();
      if (i == 9)  chk("t2_full_at_10", full_sign, 0);
      if (i == 10) chk("t2_full_at_11", full_sign, 1);
    end
    alloc_clr();
    for (int i = 0; i < 11; i++) begin
      wb_set(0, 5'(4 + i), 32'h200 + i, 0, 0);
      step();
      if (i >= 1) begin
        chk($sformatf("t2_drain_sign_%0d", i), commit_sign, 1);
        chk($sformatf("t2_drain_id_%0d", i), commit_id, 4 + i - 1);
        chk($sformatf("t2_drain_data_%0d", i), commit_data, 32'h200 + i - 1);
      end
    end
    wb_clr();
    step();
    chk("t2_drain_last_id", commit_id, 14);
    chk("t2_drain_last_data", commit_data, 32'h20A);
    chk("t2_drained_empty", empty_sign, 1);
    chk("t2_drained_full", full_sign, 0);

    // 2b: stream 40 entries from slot 14; ids wrap 16 -> 1
    for (int i = 0; i < 40; i++) ids[i] = 5'(((14 + i) % 16) + 1);
    for (int i = 0; i < 42; i++) begin
      wb_clr();
      alloc_clr();
      if (i < 40) alloc_set(5'((i % 31) + 1), 0, 0, 0, 32'h0, 32'h0);
      if (i > 0 && i <= 40) wb_set(0, ids[i-1], 32'h3000 + i - 1, 0, 0);
      step();
      if (i >= 2) begin
        chk($sformatf("t2_stream_sign_%0d", i - 2), commit_sign, 1);
        chk($sformatf("t2_stream_id_%0d", i - 2), commit_id, ids[i-2]);
        chk($sformatf("t2_stream_rd_%0d", i - 2), commit_rd, ((i - 2) % 31) + 1);
        chk($sformatf("t2_stream_data_%0d", i - 2), commit_data, 32'h3000 + i - 2);
      end
    end
    wb_clr();
    alloc_clr();
    step();
    chk("t2_stream_empty", empty_sign, 1);
    chk("t2_stream_idle", commit_sign, 0);

    // 3: dual-channel writeback to the same id, highest channel wins
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      alloc_set(5'(i), 0, 0, 0, 32'h0, 32'h0);
      step();
    end
    alloc_clr();
    wb_set(0, 5'd4, 32'h11, 0, 0);
    wb_set(1, 5'd4, 32'h22, 0, 0);
    q1_id = 5'd4;  q2_id = 5'd3;
    #1;
    chk("t3_fwd_ready", q1_ready, 1);
    chk("t3_fwd_value", v1, 32'h22);
    chk("t3_q2_not_ready", q2_ready, 0);
    chk("t3_q2_value", v2, 0);
    step();
    wb_clr();
    q2_id = '0;
    #1;
    chk("t3_entry_ready", q1_ready, 1);
    chk("t3_entry_value", v1, 32'h22);
    chk("t3_head_blocked", commit_sign, 0);
    wb_set(0, 5'd1, 32'h1, 0, 0);
    wb_set(1, 5'd2, 32'h2, 0, 0);
    step();
    wb_clr();
    wb_set(0, 5'd3, 32'h3, 0, 0);
    step();
    wb_clr();
    chk("t3_c1_data", commit_data, 32'h1);
    step();
    chk("t3_c2_data", commit_data, 32'h2);
    step();
    chk("t3_c3_data", commit_data, 32'h3);
    step();
    chk("t3_c4_sign", commit_sign, 1);
    chk("t3_c4_id", commit_id, 4);
    chk("t3_c4_data", commit_data, 32'h22);
    chk("t3_empty", empty_sign, 1);
    wb_set(0, 5'd9, 32'h99, 0, 0);
    q1_id = 5'd9;
    step();
    wb_clr();
    #1;
    chk("t3_nonbusy_ignored", q1_ready, 0);
    q1_id = '0;
    #1;
    chk("t3_q_id0_ready", q1_ready, 0);
    chk("t3_q_id0_value", v1, 0);

    // 4: mispredicted taken jump -> rollback to target, flush younger entries
    do_reset();
    alloc_set(5'd1, 1, 0, 0, 32'h40, 32'h44); step();
    alloc_set(5'd2, 0, 0, 0, 32'h44, 32'h0);  step();
    alloc_set(5'd3, 0, 0, 0, 32'h48, 32'h0);  step();
    alloc_clr();
    wb_set(0, 5'd2, 32'h2, 0, 0);
    wb_set(1, 5'd3, 32'h3, 0, 0);
    step();
    wb_clr();
    wb_set(0, 5'd1, 32'h44, 1, 32'h100);
    step();
    wb_clr();
    step();
    chk("t4_commit_sign", commit_sign, 1);
    chk("t4_commit_rd", commit_rd, 1);
    chk("t4_commit_data", commit_data, 32'h44);
    chk("t4_pdt_en", pdt_en, 1);
    chk("t4_pdt_pc", pdt_pc, 32'h40);
    chk("t4_pdt_jump", pdt_jump, 1);
    chk("t4_rollback", rollback_sign, 1);
    chk("t4_rollback_pc", rollback_pc, 32'h100);
    alloc_set(5'd6, 0, 0, 0, 32'h0, 32'h0);
    wb_set(0, 5'd2, 32'h55, 0, 0);
    step();
    alloc_clr();
    wb_clr();
    chk("t4_rollback_pulse_end", rollback_sign, 0);
    chk("t4_flush_no_commit", commit_sign, 0);
    chk("t4_flush_no_pdt", pdt_en, 0);
    chk("t4_flush_empty", empty_sign, 1);
    chk("t4_flush_alloc_id", alloc_id, 1);
    chk("t4_pdt_pc_hold", pdt_pc, 32'h40);
    step();
    step();
    chk("t4_younger_never_commit", commit_sign, 0);
    chk("t4_still_empty", empty_sign, 1);
    // predicted taken, resolved not taken -> rollback to the entry's fall-through pc
    alloc_set(5'd0, 1, 1, 0, 32'h60, 32'h80);
    step();
    alloc_clr();
    wb_set(0, 5'd1, 32'h0, 0, 32'h200);
    step();
    wb_clr();
    step();
    chk("t4b_rollback", rollback_sign, 1);
    chk("t4b_rollback_pc", rollback_pc, 32'h80);
    chk("t4b_pdt_jump", pdt_jump, 0);
    chk("t4b_rd0_no_commit", commit_sign, 0);
    step();
    chk("t4b_flushed", empty_sign, 1);

    // 5: store at head waits for store_ack, younger entry behind it stalls
    do_reset();
    alloc_set(5'd0, 0, 0, 1, 32'h10, 32'h0); step();
    alloc_set(5'd7, 0, 0, 0, 32'h14, 32'h0); step();
    alloc_clr();
    wb_set(0, 5'd1, 32'h0, 0, 0);
    wb_set(1, 5'd2, 32'h70, 0, 0);
    step();
    wb_clr();
    step();
    chk("t5_store_valid", store_commit_valid, 1);
    chk("t5_store_id", store_commit_id, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t5_wait_valid_%0d", i), store_commit_valid, 1);
      chk($sformatf("t5_wait_no_commit_%0d", i), commit_sign, 0);
    end
    store_ack = 1'b1;
    step();
    store_ack = 1'b0;
    chk("t5_ack_valid_drop", store_commit_valid, 0);
    chk("t5_ack_no_commit", commit_sign, 0);
    chk("t5_ack_not_empty", empty_sign, 0);
    step();
    chk("t5_younger_sign", commit_sign, 1);
    chk("t5_younger_rd", commit_rd, 7);
    chk("t5_younger_id", commit_id, 2);
    chk("t5_younger_data", commit_data, 32'h70);
    chk("t5_empty", empty_sign, 1);

    // 6: rdy low freezes a ready head; reset during STORE_WAIT returns to RUN
    do_reset();
    alloc_set(5'd9, 0, 0, 0, 32'h0, 32'h0);
    step();
    alloc_clr();
    wb_set(0, 5'd1, 32'h55, 0, 0);
    step();
    wb_clr();
    rdy = 1'b0;
    alloc_set(5'd3, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t6_stall_no_commit_%0d", i), commit_sign, 0);
      chk($sformatf("t6_stall_alloc_id_%0d", i), alloc_id, 2);
      chk($sformatf("t6_stall_not_empty_%0d", i), empty_sign, 0);
    end
    alloc_clr();
    rdy = 1'b1;
    step();
    chk("t6_resume_sign", commit_sign, 1);
    chk("t6_resume_rd", commit_rd, 9);
    chk("t6_resume_data", commit_data, 32'h55);
    alloc_set(5'd0, 0, 0, 1, 32'h0, 32'h0);
    step();
    alloc_clr();
    wb_set(0, 5'd2, 32'h0, 0, 0);
    step();
    wb_clr();
    step();
    chk("t6_store_valid", store_commit_valid, 1);
    chk("t6_store_id", store_commit_id, 2);
    rst = 1'b1;
    rdy = 1'b0;
    step();
    rst = 1'b0;
    rdy = 1'b1;
    chk("t6_rst_store_valid", store_commit_valid, 0);
    chk("t6_rst_empty", empty_sign, 1);
    chk("t6_rst_commit_rd", commit_rd, 0);
    chk("t6_rst_commit_data", commit_data, 0);
    alloc_set(5'd4, 0, 0, 0, 32'h0, 32'h0);
    step();
    alloc_clr();
    wb_set(0, 5'd1, 32'h77, 0, 0);
    step();
    wb_clr();
    step();
    chk("t6_run_commit_sign", commit_sign, 1);
    chk("t6_run_commit_rd", commit_rd, 4);
    chk("t6_run_commit_data", commit_data, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
